// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - registered 32-bit integer ALU with NZCV flags
//
// Purpose: combines operands a and b under a 4-bit op code. The result and
// flags are computed combinationally and captured once per rising clock
// edge, giving a fixed latency of one cycle with no handshake.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous active-high reset (clears res and flags)
//   a      in  32   operand A, two's complement
//   b      in  32   operand B; full unsigned value is the shift amount
//   op     in   4   operation select (0 ADD .. 9 SLTU, 10-15 undefined)
//   res    out 32   registered result
//   flags  out  4   registered flags {N, Z, C, V}
//
// Configuration macro: ALU_SLT_EN
//   defined   - ops 8 (SLT) and 9 (SLTU) are implemented
//   undefined - ops 8 and 9 behave as undefined ops (res = 0, Z = 1) and the
//               comparator logic is not built

module alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] res,
    output logic [3:0]  flags
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_t;

    // One shared 33-bit adder serves both ADD and SUB: for SUB the B operand
    // is inverted and the carry-in set, so bit 32 is the "no borrow" carry.
    logic        is_sub;
    logic [31:0] add_b;
    logic [32:0] add_sum;

    assign is_sub  = (op == OP_SUB);
    assign add_b   = is_sub ? ~b : b;
    assign add_sum = {1'b0, a} + {1'b0, add_b} + {32'd0, is_sub};

    // Shift amount is the full 32-bit b; any set bit above bit 4 means the
    // amount is 32 or more, which pushes every original bit out.
    logic        shift_big;
    logic [4:0]  shamt;
    logic [31:0] sll_val;
    logic [31:0] srl_val;
    logic [31:0] sra_val;

    assign shift_big = |b[31:5];
    assign shamt     = b[4:0];
    assign sll_val   = shift_big ? 32'd0 : (a << shamt);
    assign srl_val   = shift_big ? 32'd0 : (a >> shamt);
    assign sra_val   = shift_big ? {32{a[31]}} : 32'($signed(a) >>> shamt);

`ifdef ALU_SLT_EN
    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = ($signed(a) < $signed(b));
    assign lt_unsigned = (a < b);
`endif

    logic [31:0] res_d;
    logic        c_d;
    logic        v_d;
    logic [3:0]  flags_d;

    always_comb begin
        res_d = 32'd0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (op)
            OP_ADD: begin
                res_d = add_sum[31:0];
                c_d   = add_sum[32];
                // Overflow when both operands share a sign the result lost.
                v_d   = (a[31] == b[31]) && (add_sum[31] != a[31]);
            end
            OP_SUB: begin
                res_d = add_sum[31:0];
                c_d   = add_sum[32];
                v_d   = (a[31] != b[31]) && (add_sum[31] != a[31]);
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_SLL:  res_d = sll_val;
            OP_SRL:  res_d = srl_val;
            OP_SRA:  res_d = sra_val;
`ifdef ALU_SLT_EN
            OP_SLT:  res_d = {31'd0, lt_signed};
            OP_SLTU: res_d = {31'd0, lt_unsigned};
`endif
            default: res_d = 32'd0;
        endcase
    end

    assign flags_d = {res_d[31], (res_d == 32'd0), c_d, v_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res   <= 32'd0;
            flags <= 4'b0000;
        end else begin
            res   <= res_d;
            flags <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit (directed + random)

module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  flags;

    int vectors     = 0;
    int miscompares = 0;

    logic        pend = 1'b0;
    logic [35:0] pexp;
    string       ptag;

    alu_unit dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .op    (op),
        .res   (res),
        .flags (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got res=%h flags=%b, expected res=%h flags=%b",
                     tag, got[31:0], got[35:32], exp[31:0], exp[35:32]);
        end
    endtask

    // Reference: 64-bit integer arithmetic straight from the operation rules.
    function automatic logic [35:0] model(input logic [31:0] ia, input logic [31:0] ib,
                                          input logic [3:0] iop);
        longint sa = longint'($signed(ia));
        longint sb = longint'($signed(ib));
        longint ua = longint'(ia);
        longint ub = longint'(ib);
        longint r  = 0;
        longint s  = 0;
        logic   c  = 1'b0;
        logic   v  = 1'b0;
        logic [31:0] r32;
        case (iop)
            4'd0: begin
                r = ua + ub;
                c = (r >= 64'sh1_0000_0000);
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r = ua + (ub ^ 64'h0000_0000_FFFF_FFFF) + 1;
                c = (r >= 64'sh1_0000_0000);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = (ub >= 32) ? 0 : (ua << ub);
            4'd6: r = (ub >= 32) ? 0 : (ua >> ub);
            4'd7: r = (ub >= 32) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
`ifdef ALU_SLT_EN
            4'd8: r = (sa < sb) ? 1 : 0;
            4'd9: r = (ua < ub) ? 1 : 0;
`endif
            default: r = 0;
        endcase
        r32 = r[31:0];
        return {r32[31], (r32 == 32'd0), c, v, r32};
    endfunction

    // Drives one operation at a falling edge; the previous operation's result
    // is checked at the same falling edge, so ops run back to back.
    task automatic step(input string tag, input logic [3:0] iop, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [35:0] exp);
        @(negedge clk);
        if (pend) check(ptag, {flags, res}, pexp);
        op   = iop;
        a    = ia;
        b    = ib;
        pexp = exp;
        ptag = tag;
        pend = 1'b1;
    endtask

    task automatic flush();
        @(negedge clk);
        if (pend) check(ptag, {flags, res}, pexp);
        pend = 1'b0;
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t dir[$];

    initial begin
        rst = 1'b1;
        a   = 32'd0;
        b   = 32'd0;
        op  = 4'd0;
        repeat (2) @(negedge clk);
        check("reset_hold", {flags, res}, 36'd0);
        rst = 1'b0;

        step("prime_or", 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, {4'b1000, 32'hFFFFFFFF});
        flush();

        // Asynchronous reset mid-cycle, away from any edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("reset_async", {flags, res}, 36'd0);
        @(posedge clk);
        #1 check("reset_held_edge", {flags, res}, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_reset_and", 4'd2, 32'hFFFFFFFF, 32'h0, {4'b0100, 32'h0});

        dir.push_back('{"and",      4'd2, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0000});
        dir.push_back('{"or",       4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000});
        dir.push_back('{"xor_neg",  4'd4, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 4'b1000});
        dir.push_back('{"xor",      4'd4, 32'h15,       32'h2A,       32'h3F,       4'b0000});
        dir.push_back('{"sll4",     4'd5, 32'h0F,       32'd4,        32'hF0,       4'b0000});
        dir.push_back('{"sll31",    4'd5, 32'h0F,       32'd31,       32'h80000000, 4'b1000});
        dir.push_back('{"sll32",    4'd5, 32'h0F,       32'd32,       32'h0,        4'b0100});
        dir.push_back('{"sll_max",  4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        4'b0100});
        dir.push_back('{"sll0",     4'd5, 32'h1234,     32'd0,        32'h1234,     4'b0000});
        dir.push_back('{"srl3",     4'd6, 32'h0F,       32'd3,        32'h1,        4'b0000});
        dir.push_back('{"srl1",     4'd6, 32'h1,        32'd1,        32'h0,        4'b0100});
        dir.push_back('{"sra40",    4'd7, 32'h80000000, 32'd40,       32'hFFFFFFFF, 4'b1000});
        dir.push_back('{"add_ovf",  4'd0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b1001});
        dir.push_back('{"add_cz",   4'd0, 32'hFFFFFFFF, 32'd1,        32'h0,        4'b0110});
        dir.push_back('{"sub_eq",   4'd1, 32'd5,        32'd5,        32'h0,        4'b0110});
        dir.push_back('{"sub_ovf",  4'd1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0011});
        dir.push_back('{"undef15",  4'd15,32'h12345678, 32'h9,        32'h0,        4'b0100});
`ifdef ALU_SLT_EN
        dir.push_back('{"slt",      4'd8, 32'hFFFFFFFF, 32'd1,        32'h1,        4'b0000});
        dir.push_back('{"sltu",     4'd9, 32'hFFFFFFFF, 32'd1,        32'h0,        4'b0100});
`else
        dir.push_back('{"op8_off",  4'd8, 32'hFFFFFFFF, 32'd1,        32'h0,        4'b0100});
        dir.push_back('{"op9_off",  4'd9, 32'd1,        32'hFFFFFFFF, 32'h0,        4'b0100});
`endif
        foreach (dir[i])
            step(dir[i].tag, dir[i].op, dir[i].a, dir[i].b, {dir[i].f, dir[i].r});

        for (int i = 0; i < 400; i++) begin
            logic [3:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if (rop inside {4'd5, 4'd6, 4'd7} && $urandom_range(0, 3) != 0)
                rb = $urandom_range(0, 40);
            if ($urandom_range(0, 7) == 0)
                rb = ra;
            step($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(ra, rb, rop));
        end

        // Reset mid-stream: the queued result must be discarded.
        step("pre_reset_add", 4'd0, 32'd7, 32'd9, model(32'd7, 32'd9, 4'd0));
        flush();
        @(negedge clk);
        op = 4'd3;
        a  = 32'hDEADBEEF;
        b  = 32'h0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1 check("reset_discard", {flags, res}, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        step("after_discard", 4'd1, 32'd3, 32'd10, model(32'd3, 32'd10, 4'd1));
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
